controle_sequenciador: RTL

CONTROLE_SEQUENCIADOR -- requirements
Module: controle_sequenciador

---
 rtl/sap1_pkg.sv | 47 ++++
 rtl/controle_sequenciador_anel_t.sv | 80 ++++++++
 rtl/controle_sequenciador.sv | 108 ++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// sap1_pkg: shared opcode encoding, one-hot T-state constants and the
// control-word layout used by the SAP-1 sequencer.
package sap1_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  typedef enum logic [5:0] {
    ST_T1 = T1,
    ST_T2 = T2,
    ST_T3 = T3,
    ST_T4 = T4,
    ST_T5 = T5,
    ST_T6 = T6
  } t_state_e;

  // Active-high: cp ep ea su eu; active-low: lm ce li ei la lb lo
  typedef struct packed {
    logic cp;
    logic ep;
    logic ea;
    logic su;
    logic eu;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic lb;
    logic lo;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_INACTIVE = ctrl_word_t'(12'b00000_1111111);

endpackage

// File: rtl/controle_sequenciador_anel_t.sv
// anel_t: one-hot T-state ring with halt freeze.
// Optional macro SAP1_EARLY_RETURN_EN: jump back to T1 right after the last
// execute state that does any work (LDA after T5, OUT/undefined after T4).
//
// state | meaning
// T1    | fetch: PC to MAR
// T2    | fetch: PC increment
// T3    | fetch: RAM to IR
// T4    | execute step 1 (frozen here once halted)
// T5    | execute step 2
// T6    | execute step 3
module anel_t
  import sap1_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [OPCODE_W-1:0] op_code,
  output logic [5:0]          t_estado,
  output logic                halt
);

  t_state_e state, state_nxt;
  logic     halt_nxt;
  logic     op_hlt;
  logic     ret_t4;
  logic     ret_t5;

  assign op_hlt = (op_code == OPCODE_W'(OP_HLT));

`ifdef SAP1_EARLY_RETURN_EN
  logic op_lda, op_out, op_undef;
  assign op_lda   = (op_code == OPCODE_W'(OP_LDA));
  assign op_out   = (op_code == OPCODE_W'(OP_OUT));
  assign op_undef = !(op_lda || op_out || op_hlt ||
                      (op_code == OPCODE_W'(OP_ADD)) ||
                      (op_code == OPCODE_W'(OP_SUB)));
  assign ret_t4   = op_out || op_undef;
  assign ret_t5   = op_lda;
`else
  assign ret_t4   = 1'b0;
  assign ret_t5   = 1'b0;
`endif

  // State and halt flag registers, async clear back to T1
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= ST_T1;
      halt  <= 1'b0;
    end else begin
      state <= state_nxt;
      halt  <= halt_nxt;
    end
  end

  // Ring advance; HLT in T4 latches halt and holds the ring at T4
  always_comb begin
    state_nxt = state;
    halt_nxt  = halt;
    if (!halt) begin
      case (state)
        ST_T1: state_nxt = ST_T2;
        ST_T2: state_nxt = ST_T3;
        ST_T3: state_nxt = ST_T4;
        ST_T4: begin
          if (op_hlt)      halt_nxt  = 1'b1;
          else if (ret_t4) state_nxt = ST_T1;
          else             state_nxt = ST_T5;
        end
        ST_T5: state_nxt = ret_t5 ? ST_T1 : ST_T6;
        ST_T6: state_nxt = ST_T1;
        default: state_nxt = ST_T1;
      endcase
    end
  end

  assign t_estado = state;

endmodule

// File: rtl/controle_sequenciador.sv
// controle_sequenciador: SAP-1 control sequencer. The anel_t ring supplies
// the T-state and halt flag; control outputs are decoded combinationally
// here. Optional macro SAP1_EARLY_RETURN_EN (handled inside anel_t)
// shortens LDA, OUT and undefined opcodes.
module controle_sequenciador
  import sap1_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [OPCODE_W-1:0] op_code,
  output logic [5:0]          t_estado,
  output logic                ciclo_busca,
  output logic                Cp,
  output logic                Ep,
  output logic                Ea,
  output logic                Su,
  output logic                Eu,
  output logic                Lm,
  output logic                Ce,
  output logic                Li,
  output logic                Ei,
  output logic                La,
  output logic                Lb,
  output logic                Lo,
  output logic                hlt
);

  logic       halt;
  ctrl_word_t ctrl;
  logic       op_lda, op_add, op_sub, op_out;

  anel_t #(.OPCODE_W(OPCODE_W)) u_anel (
    .CLK      (CLK),
    .CLR      (CLR),
    .op_code  (op_code),
    .t_estado (t_estado),
    .halt     (halt)
  );

  assign op_lda = (op_code == OPCODE_W'(OP_LDA));
  assign op_add = (op_code == OPCODE_W'(OP_ADD));
  assign op_sub = (op_code == OPCODE_W'(OP_SUB));
  assign op_out = (op_code == OPCODE_W'(OP_OUT));

  // Control-word decode; CLR gates directly so an async clear blanks
  // the controls without waiting for the register to settle
  always_comb begin
    ctrl = CTRL_INACTIVE;
    if (!CLR && !halt) begin
      case (t_estado)
        T1: begin
          ctrl.ep = 1'b1;
          ctrl.lm = 1'b0;
        end
        T2: ctrl.cp = 1'b1;
        T3: begin
          ctrl.ce = 1'b0;
          ctrl.li = 1'b0;
        end
        T4: begin
          if (op_lda || op_add || op_sub) begin
            ctrl.ei = 1'b0;
            ctrl.lm = 1'b0;
          end else if (op_out) begin
            ctrl.ea = 1'b1;
            ctrl.lo = 1'b0;
          end
        end
        T5: begin
          if (op_lda) begin
            ctrl.ce = 1'b0;
            ctrl.la = 1'b0;
          end else if (op_add || op_sub) begin
            ctrl.ce = 1'b0;
            ctrl.lb = 1'b0;
          end
        end
        T6: begin
          if (op_add || op_sub) begin
            ctrl.eu = 1'b1;
            ctrl.la = 1'b0;
            ctrl.su = op_sub;
          end
        end
        default: ;
      endcase
    end
  end

  assign ciclo_busca = !CLR && ((t_estado == T1) || (t_estado == T2) || (t_estado == T3));
  assign hlt         = halt;

  assign Cp = ctrl.cp;
  assign Ep = ctrl.ep;
  assign Ea = ctrl.ea;
  assign Su = ctrl.su;
  assign Eu = ctrl.eu;
  assign Lm = ctrl.lm;
  assign Ce = ctrl.ce;
  assign Li = ctrl.li;
  assign Ei = ctrl.ei;
  assign La = ctrl.la;
  assign Lb = ctrl.lb;
  assign Lo = ctrl.lo;

endmodule
